// File: rtl/imem_loadable.sv
// Loadable instruction memory. A loader writes the program image word by word
// over a valid/ready port. Once loaded, the fetch port serves word reads through
// a READ_LATENCY-deep response pipeline. Misaligned and out-of-range fetches are
// flagged as faults and return a NOP.
module imem_loadable #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 256,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     load_valid,
    input  logic [DATA_WIDTH-1:0]    load_data,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic                     load_done,
    output logic [$clog2(DEPTH):0]   load_count,
    input  logic                     fetch_req,
    input  logic [ADDR_WIDTH-1:0]    fetch_addr,
    output logic                     fetch_ready,
    output logic                     fetch_valid,
    output logic [DATA_WIDTH-1:0]    fetch_data,
    output logic                     fetch_fault
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                  state;
    logic [AW-1:0]           ptr;
    // Zero initialisation gives never-written words a defined value; reset
    // deliberately leaves the array alone so a program survives a core reset.
    logic [DATA_WIDTH-1:0]   mem [DEPTH] = '{default: '0};

    logic                    load_acc;
    logic                    load_end;
    logic                    fetch_acc;
    logic                    fault_p0;
    logic [AW-1:0]           idx_p0;

    logic                    vld_p1;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic                    fault_p1;

    // Fault when the byte address is not word aligned or any address bit above
    // the word index is set (word index >= DEPTH).
    function automatic logic addr_fault(input logic [ADDR_WIDTH-1:0] a);
        logic hi;
        hi = 1'b0;
        for (int i = AW + 2; i < ADDR_WIDTH; i++) begin
            hi = hi | a[i];
        end
        return (a[1:0] != 2'b00) || hi;
    endfunction

    // load_start takes priority, so a word presented alongside it is dropped
    assign load_acc  = load_ready && load_valid && !load_start;
    assign load_end  = load_acc && (load_last || (ptr == AW'(DEPTH - 1)));
    assign fetch_acc = fetch_req && fetch_ready;
    assign fault_p0  = addr_fault(fetch_addr);
    assign idx_p0    = fetch_addr[AW+1:2];

    // Control FSM; ready flags are registered decodes of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            load_count  <= '0;
            load_done   <= 1'b0;
            load_ready  <= 1'b0;
            fetch_ready <= 1'b0;
        end else if (load_start) begin
            state       <= LOAD;
            ptr         <= '0;
            load_count  <= '0;
            load_done   <= 1'b0;
            load_ready  <= 1'b1;
            fetch_ready <= 1'b0;
        end else if (load_acc) begin
            ptr        <= ptr + 1'b1;
            load_count <= load_count + 1'b1;
            if (load_end) begin
                state       <= RUN;
                load_done   <= 1'b1;
                load_ready  <= 1'b0;
                fetch_ready <= 1'b1;
            end
        end
    end

    // Program image write port
    always_ff @(posedge clk) begin
        if (load_acc) begin
            mem[ptr] <= load_data;
        end
    end

    // ---- stage p0 -> p1: read at acceptance, fault replaces the read ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            fault_p1 <= 1'b0;
        end else begin
            vld_p1 <= fetch_acc;
            if (fetch_acc) begin
                fault_p1 <= fault_p0;
                data_p1  <= fault_p0 ? NOP_WORD : mem[idx_p0];
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  vld_p2;
            logic [DATA_WIDTH-1:0] data_p2;
            logic                  fault_p2;

            // ---- stage p1 -> p2: extra response register ----
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_p2   <= 1'b0;
                    data_p2  <= '0;
                    fault_p2 <= 1'b0;
                end else begin
                    vld_p2 <= vld_p1;
                    if (vld_p1) begin
                        data_p2  <= data_p1;
                        fault_p2 <= fault_p1;
                    end
                end
            end

            assign fetch_valid = vld_p2;
            assign fetch_data  = data_p2;
            assign fetch_fault = fault_p2;
        end else begin : g_lat1
            assign fetch_valid = vld_p1;
            assign fetch_data  = data_p1;
            assign fetch_fault = fault_p1;
        end
    endgenerate

endmodule
